// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level master: command codes, phase
// states and the per-phase open-drain line levels.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_CMD_START = 2'b00,
    I2C_CMD_STOP  = 2'b01,
    I2C_CMD_WRITE = 2'b10,
    I2C_CMD_READ  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_Q0,
    ST_Q1,
    ST_Q2,
    ST_Q3
  } state_t;

  // Returns {scl_oe, sda_oe} for a command in a given quarter phase.
  // 1 means pull the line low, 0 means release it.
  function automatic logic [1:0] phase_lines(cmd_t c, logic b, state_t p);
    logic scl;
    logic sda;
    scl = 1'b0;
    sda = 1'b0;
    case (c)
      I2C_CMD_START: begin
        scl = (p == ST_Q3);
        sda = (p == ST_Q2) || (p == ST_Q3);
      end
      I2C_CMD_STOP: begin
        scl = (p == ST_Q0);
        sda = (p != ST_Q3);
      end
      I2C_CMD_WRITE: begin
        scl = (p == ST_Q0) || (p == ST_Q3);
        sda = ~b;
      end
      I2C_CMD_READ: begin
        scl = (p == ST_Q0) || (p == ST_Q3);
        sda = 1'b0;
      end
      default: begin
        scl = 1'b0;
        sda = 1'b0;
      end
    endcase
    return {scl, sda};
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// Command handshake and pad-side signals of the I2C bit controller.
// master: byte-level FSM plus pad model; slave: the bit controller.
interface i2c_bit_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_bit;
  logic       done;
  logic       rd_bit;
  logic       arb_lost;
  logic       busy;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    output cmd_valid, cmd, cmd_bit, scl_in, sda_in,
    input  cmd_ready, done, rd_bit, arb_lost, busy, scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bit, scl_in, sda_in,
    output cmd_ready, done, rd_bit, arb_lost, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_qtr_timer.sv
// Quarter-period down-counter. tc pulses in the last cycle of each phase;
// the counter reloads on tc or load and freezes while stall is high.
module i2c_qtr_timer #(
  parameter int unsigned QTR   = 250,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic stall,
  output logic tc
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QTR - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = run && !stall && (cnt == '0);

  // Count down while running and not stalled; reload at phase boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || tc) begin
      cnt <= RELOAD;
    end else if (run && !stall) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level master: drives START, STOP, WRITE and READ waveforms as
// four quarter phases on open-drain SCL/SDA, with clock stretching in Q1,
// read sampling and arbitration-loss abort at the end of Q1/Q2.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned QTR   = 250,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  i2c_bit_ctrl_if.slave bus
);

  state_t     state, state_nx;
  cmd_t       cmd_q, cmd_nx;
  logic       bit_q, bit_nx;
  logic [1:0] lines_q, lines_nx;
  logic       done_q, done_nx;
  logic       arb_q, arb_nx;
  logic       rd_q, rd_nx;
  logic       busy_q;
  logic       ready_q;

  logic accept;
  logic stall;
  logic tc;

  assign accept = bus.cmd_valid && ready_q;
  // A slave may hold SCL low after we release it in Q1 (not during START).
  assign stall  = (state == ST_Q1) && (cmd_q != I2C_CMD_START) && !bus.scl_in;

  i2c_qtr_timer #(
    .QTR   (QTR),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .run   (state != ST_IDLE),
    .stall (stall),
    .tc    (tc)
  );

  // Next phase, next line levels and completion flags.
  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    bit_nx   = bit_q;
    lines_nx = lines_q;
    done_nx  = 1'b0;
    arb_nx   = 1'b0;
    rd_nx    = rd_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cmd_nx   = cmd_t'(bus.cmd);
          bit_nx   = bus.cmd_bit;
          state_nx = ST_Q0;
          lines_nx = phase_lines(cmd_t'(bus.cmd), bus.cmd_bit, ST_Q0);
        end
      end
      ST_Q0: begin
        if (tc) begin
          state_nx = ST_Q1;
          lines_nx = phase_lines(cmd_q, bit_q, ST_Q1);
        end
      end
      ST_Q1: begin
        if (tc) begin
          if ((cmd_q == I2C_CMD_START) && !bus.sda_in) begin
            state_nx = ST_IDLE;
            lines_nx = '0;
            done_nx  = 1'b1;
            arb_nx   = 1'b1;
          end else begin
            state_nx = ST_Q2;
            lines_nx = phase_lines(cmd_q, bit_q, ST_Q2);
          end
        end
      end
      ST_Q2: begin
        if (tc) begin
          if (cmd_q == I2C_CMD_READ) begin
            rd_nx = bus.sda_in;
          end
          if ((cmd_q == I2C_CMD_WRITE) && bit_q && !bus.sda_in) begin
            state_nx = ST_IDLE;
            lines_nx = '0;
            done_nx  = 1'b1;
            arb_nx   = 1'b1;
          end else begin
            state_nx = ST_Q3;
            lines_nx = phase_lines(cmd_q, bit_q, ST_Q3);
          end
        end
      end
      ST_Q3: begin
        if (tc) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        lines_nx = '0;
      end
    endcase
  end

  // State and registered outputs; busy/ready derive from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd_q   <= I2C_CMD_START;
      bit_q   <= 1'b0;
      lines_q <= '0;
      done_q  <= 1'b0;
      arb_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      cmd_q   <= cmd_nx;
      bit_q   <= bit_nx;
      lines_q <= lines_nx;
      done_q  <= done_nx;
      arb_q   <= arb_nx;
      rd_q    <= rd_nx;
      busy_q  <= (state_nx != ST_IDLE);
      ready_q <= (state_nx == ST_IDLE);
    end
  end

  assign bus.scl_oe    = lines_q[1];
  assign bus.sda_oe    = lines_q[0];
  assign bus.done      = done_q;
  assign bus.arb_lost  = arb_q;
  assign bus.rd_bit    = rd_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_ready = ready_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with QTR=4. Pads are modelled as
// wired-AND: a line reads high unless the DUT or the bench pulls it low.
module tb_i2c_bit_ctrl;

  logic clk;
  logic rst;
  logic scl_hold;
  logic sda_force;

  int unsigned vectors;
  int unsigned miscompares;

  logic tr_scl   [64];
  logic tr_sda   [64];
  logic tr_done  [64];
  logic tr_arb   [64];
  logic tr_rd    [64];
  logic tr_busy  [64];
  logic tr_ready [64];

  i2c_bit_ctrl_if bus ();

  assign bus.scl_in = ~bus.scl_oe & ~scl_hold;
  assign bus.sda_in = ~bus.sda_oe & ~sda_force;

  i2c_bit_ctrl #(
    .QTR   (4),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 presents the command; cycles 1..n are recorded after each edge.
  // Windows (lo..hi) hold SCL low / force SDA low; rst_at and extra_at pulse
  // rst / cmd_valid in a single cycle. Negative values disable them.
  task automatic run_cmd(input logic [1:0] c, input logic b, input int n,
                         input int hold_lo, input int hold_hi,
                         input int force_lo, input int force_hi,
                         input int rst_at, input int extra_at);
    bus.cmd       = c;
    bus.cmd_bit   = b;
    bus.cmd_valid = 1'b1;
    scl_hold      = 1'b0;
    sda_force     = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      bus.cmd_valid = (k == extra_at);
      scl_hold      = (k >= hold_lo) && (k <= hold_hi);
      sda_force     = (k >= force_lo) && (k <= force_hi);
      rst           = (k == rst_at);
      tr_scl[k]   = bus.scl_oe;
      tr_sda[k]   = bus.sda_oe;
      tr_done[k]  = bus.done;
      tr_arb[k]   = bus.arb_lost;
      tr_rd[k]    = bus.rd_bit;
      tr_busy[k]  = bus.busy;
      tr_ready[k] = bus.cmd_ready;
    end
    bus.cmd_valid = 1'b0;
    scl_hold      = 1'b0;
    sda_force     = 1'b0;
    rst           = 1'b0;
  endtask

  initial begin
    int nd;
    int sda_ones;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    scl_hold      = 1'b0;
    sda_force     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.cmd_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_scl_oe",   bus.scl_oe,    0);
    chk("rst_sda_oe",   bus.sda_oe,    0);
    chk("rst_done",     bus.done,      0);
    chk("rst_arb_lost", bus.arb_lost,  0);
    chk("rst_rd_bit",   bus.rd_bit,    0);
    chk("rst_busy",     bus.busy,      0);
    chk("rst_ready",    bus.cmd_ready, 1);

    // START
    run_cmd(2'b00, 1'b0, 20, -1, -1, -1, -1, -1, -1);
    chk("start_busy1",   tr_busy[1],  1);
    chk("start_ready1",  tr_ready[1], 0);
    chk("start_sda8",    tr_sda[8],   0);
    chk("start_sda9",    tr_sda[9],   1);
    chk("start_scl12",   tr_scl[12],  0);
    chk("start_scl13",   tr_scl[13],  1);
    chk("start_done16",  tr_done[16], 0);
    chk("start_done17",  tr_done[17], 1);
    chk("start_ready17", tr_ready[17], 1);
    chk("start_arb17",   tr_arb[17],  0);
    chk("start_done18",  tr_done[18], 0);
    chk("start_hold19",  {tr_scl[19], tr_sda[19]}, 2'b11);

    // WRITE 0
    run_cmd(2'b10, 1'b0, 20, -1, -1, -1, -1, -1, -1);
    sda_ones = 0;
    for (int k = 1; k <= 16; k++) sda_ones += int'(tr_sda[k]);
    chk("wr0_sda_low_1_16", sda_ones, 16);
    chk("wr0_scl4",    tr_scl[4],   1);
    chk("wr0_scl5",    tr_scl[5],   0);
    chk("wr0_scl12",   tr_scl[12],  0);
    chk("wr0_scl13",   tr_scl[13],  1);
    chk("wr0_done16",  tr_done[16], 0);
    chk("wr0_done17",  tr_done[17], 1);
    chk("wr0_arb17",   tr_arb[17],  0);

    // READ, line high at sample point
    run_cmd(2'b11, 1'b0, 20, -1, -1, -1, -1, -1, -1);
    sda_ones = 0;
    for (int k = 1; k <= 17; k++) sda_ones += int'(tr_sda[k]);
    chk("rd1_sda_released", sda_ones, 0);
    chk("rd1_scl13",   tr_scl[13],  1);
    chk("rd1_done17",  tr_done[17], 1);
    chk("rd1_rd_bit",  tr_rd[17],   1);

    // READ, line pulled low only in the sample cycle
    run_cmd(2'b11, 1'b0, 20, -1, -1, 12, 12, -1, -1);
    chk("rd0_done17",  tr_done[17], 1);
    chk("rd0_rd_bit",  tr_rd[17],   0);
    chk("rd0_rd_hold", tr_rd[20],   0);

    // WRITE 1 with SCL stretched for 10 cycles after release
    run_cmd(2'b10, 1'b1, 30, 5, 14, -1, -1, -1, -1);
    chk("str_busy20",  tr_busy[20], 1);
    chk("str_scl22",   tr_scl[22],  0);
    chk("str_scl23",   tr_scl[23],  1);
    chk("str_done17",  tr_done[17], 0);
    chk("str_done26",  tr_done[26], 0);
    chk("str_done27",  tr_done[27], 1);
    chk("str_arb27",   tr_arb[27],  0);

    // WRITE 1 losing arbitration at the sample point
    run_cmd(2'b10, 1'b1, 16, -1, -1, 12, 12, -1, -1);
    chk("arbw_done12",  tr_done[12],  0);
    chk("arbw_done13",  tr_done[13],  1);
    chk("arbw_arb13",   tr_arb[13],   1);
    chk("arbw_lines13", {tr_scl[13], tr_sda[13]}, 2'b00);
    chk("arbw_ready13", tr_ready[13], 1);
    chk("arbw_busy13",  tr_busy[13],  0);
    chk("arbw_done14",  tr_done[14],  0);
    chk("arbw_arb14",   tr_arb[14],   0);

    // START with SDA already held low by another master
    run_cmd(2'b00, 1'b0, 12, -1, -1, 8, 8, -1, -1);
    chk("arbs_done8",  tr_done[8], 0);
    chk("arbs_done9",  tr_done[9], 1);
    chk("arbs_arb9",   tr_arb[9],  1);
    chk("arbs_lines9", {tr_scl[9], tr_sda[9]}, 2'b00);

    // STOP interrupted by reset in cycle 7
    run_cmd(2'b01, 1'b0, 20, -1, -1, -1, -1, 7, -1);
    chk("stop_lines4",  {tr_scl[4], tr_sda[4]}, 2'b11);
    chk("stop_lines7",  {tr_scl[7], tr_sda[7]}, 2'b01);
    chk("stop_busy7",   tr_busy[7],  1);
    chk("stop_lines8",  {tr_scl[8], tr_sda[8]}, 2'b00);
    chk("stop_busy8",   tr_busy[8],  0);
    chk("stop_ready8",  tr_ready[8], 1);
    nd = 0;
    for (int k = 1; k <= 20; k++) nd += int'(tr_done[k]);
    chk("stop_no_done", nd, 0);

    // WRITE 0 with a stray cmd_valid while busy
    run_cmd(2'b10, 1'b0, 30, -1, -1, -1, -1, -1, 5);
    nd = 0;
    for (int k = 1; k <= 30; k++) nd += int'(tr_done[k]);
    chk("busy_done_count", nd, 1);
    chk("busy_done17",     tr_done[17], 1);
    chk("busy_idle20",     tr_busy[20], 0);
    chk("busy_ready20",    tr_ready[20], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
